timer_sequencer: RTL and testbench

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/timer_sequencer.sv | 162 ++++++++++++++++
 tb/tb_timer_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer sequencer and its prescaler.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam int CLEAR_CYCLES = 2;
    localparam int CLR_CNT_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts while enabled, flags a tick when the count
// equals the period and wraps to zero; held at zero while disabled.
module tick_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // Equality compare keeps the counter inside period, so it can never wrap.
    always_comb begin
        tick = enable && (cnt_q == period);
        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Timed-run sequencer driving a downstream tick counter (IDLE/ARM/COUNT/CLEAR).
// Optional watchdog abort enabled by defining TIMER_SEQUENCER_WATCHDOG_EN.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int WDOG_TICKS = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  reached,
    output logic                  tick,
    output logic                  run,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    if (WDOG_TICKS < 1 || PRESCALE_W < 1) begin : g_param_chk
        $error("timer_sequencer: WDOG_TICKS and PRESCALE_W must be at least 1");
    end

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [CLR_CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [1:0]            rst_sync_q, rst_sync_d;
    logic                  reached_q;
    logic                  tick_q, tick_d;
    logic                  run_q, run_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pre_tick;
    logic                  abort;

`ifdef TIMER_SEQUENCER_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_TICKS + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    assign abort   = timeout_q;
    assign timeout = timeout_q;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q == ST_COUNT),
        .period (period_q),
        .tick   (pre_tick)
    );

    // Start is only accepted once the released reset has crossed two flops.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        state_d    = state_q;
        period_d   = period_q;
        clr_cnt_d  = clr_cnt_q;
        run_d      = run_q;
        busy_d     = busy_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && rst_sync_q[1]) begin
                    period_d = (prescale == '0) ? PRESCALE_W'(1) : prescale;
                    state_d  = ST_ARM;
                    run_d    = 1'b1;
                    busy_d   = 1'b1;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
                    wd_cnt_d  = WD_W'(WDOG_TICKS);
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_ARM: begin
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (reached_q) begin
                    state_d   = ST_CLEAR;
                    run_d     = 1'b0;
                    clr_cnt_d = CLR_CNT_W'(CLEAR_CYCLES - 1);
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
                end else if (wd_cnt_q == '0) begin
                    state_d   = ST_CLEAR;
                    run_d     = 1'b0;
                    timeout_d = 1'b1;
                    clr_cnt_d = CLR_CNT_W'(CLEAR_CYCLES - 1);
`endif
                end else begin
                    // Raw reached also masks so tick never overlaps reached_q.
                    tick_d = pre_tick && !reached;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
                    if (tick_d) begin
                        wd_cnt_d = wd_cnt_q - WD_W'(1);
                    end
`endif
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q - CLR_CNT_W'(1);
                    done_d    = (clr_cnt_q == CLR_CNT_W'(1)) && !abort;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
            state_q    <= ST_IDLE;
            period_q   <= PRESCALE_W'(1);
            clr_cnt_q  <= '0;
            reached_q  <= 1'b0;
            tick_q     <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            rst_sync_q <= rst_sync_d;
            state_q    <= state_d;
            period_q   <= period_d;
            clr_cnt_q  <= clr_cnt_d;
            reached_q  <= reached;
            tick_q     <= tick_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign tick = tick_q;
    assign run  = run_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed + randomized bench for timer_sequencer with a cycle-index reference model.
module tb_timer_sequencer;

    localparam int PW = 4;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 1 << 30;
`endif
    localparam int NEVER = 1 << 30;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] prescale;
    logic          reached;
    logic          tick, run, busy, done, timeout;

    int vecs;
    int errs;
    bit sticky_to;

    timer_sequencer #(.PRESCALE_W(PW), .WDOG_TICKS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .prescale (prescale),
        .reached  (reached),
        .tick     (tick),
        .run      (run),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int n, input logic obs, input logic expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s @cycle %0d: observed %b expected %b", tag, n, obs, expv);
        end
    endtask

    task automatic check_quiet(input string tag, input int n);
        check({tag, "_run"},     n, run,     1'b0);
        check({tag, "_tick"},    n, tick,    1'b0);
        check({tag, "_busy"},    n, busy,    1'b0);
        check({tag, "_done"},    n, done,    1'b0);
        check({tag, "_timeout"}, n, timeout, 1'b0);
    endtask

    // One run: n counts rising edges since the start edge (n=0 is the ARM cycle).
    // Ticks land at n = P+2 + m*(P+1); reached sampled at edge ra ends COUNT at ra+1.
    task automatic run_seq(input int p_in, input int k, input bit disturb);
        int P, n, ra, ec, ticks;
        bit to_flag, exp_tick;
        P = (p_in == 0) ? 1 : p_in;
        ra = NEVER;
        ec = NEVER;
        ticks = 0;
        to_flag = 1'b0;
        check("idle_busy", -1, busy, 1'b0);
        check("idle_timeout_sticky", -1, timeout, sticky_to);
        if (k == 0) begin
            reached = 1'b1;
            ra = 0;
            ec = 2;
        end
        start = 1'b1;
        prescale = PW'(p_in);
        n = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            prescale = PW'($urandom_range(0, (1 << PW) - 1));
            exp_tick = (n >= P + 2) && (((n - (P + 2)) % (P + 1)) == 0) && (n < ra) && (ticks < WD);
            if (exp_tick) ticks++;
            if (exp_tick && ticks == WD && ec == NEVER) begin
                ec = n + 1;
                to_flag = 1'b1;
            end
            if (exp_tick && ticks == k && ra == NEVER) begin
                reached = 1'b1;
                ra = n + 1;
                if (ec == NEVER) ec = (ra + 1 > 2) ? ra + 1 : 2;
            end
            check("tick",    n, tick,    exp_tick);
            check("run",     n, run,     n < ec);
            check("busy",    n, busy,    n < ec + 2);
            check("done",    n, done,    (n == ec + 1) && !to_flag);
            check("timeout", n, timeout, to_flag && (n >= ec));
            if (n == ec + 2) break;
            if (disturb && (n == 1 || n == P + 4 || n == ec + 1) && (n + 1 <= ec + 1)) begin
                start = 1'b1;
                prescale = PW'(7);
            end
            n++;
            if (n > 4000) begin
                check("run_bound", n, 1'b1, 1'b0);
                break;
            end
        end
        reached = 1'b0;
        sticky_to = to_flag;
        @(negedge clk);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        sticky_to = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        prescale = '0;
        reached = 1'b0;

        repeat (2) @(negedge clk);
        check_quiet("reset", 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // prescale=3, reached after 10th tick
        run_seq(3, 10, 1'b0);
        // prescale=0: 2-cycle period
        run_seq(0, 5, 1'b0);
        // prescale=1 also 2-cycle period
        run_seq(1, 3, 1'b0);
        // start pulses while busy with a different prescale
        run_seq(2, 6, 1'b1);
        // reached high before start: zero ticks, done pulse
        run_seq(4, 0, 1'b0);
        // all-ones prescale: period 2^PW
        run_seq((1 << PW) - 1, 2, 1'b1);
        // long wait: watchdog abort if enabled, otherwise waits for reached
        run_seq(1, 20, 1'b0);
        // next start clears timeout
        run_seq(2, 1, 1'b0);

        // reset mid-COUNT
        start = 1'b1;
        prescale = PW'(2);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid", 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_quiet("rst_hold", i);
        end
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_release_busy", 1, busy, 1'b0);
        @(negedge clk);
        check_quiet("rst_release", 2);
        sticky_to = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 12; r++) begin
            run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 10)), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
